// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone GPIO bank with synchronized inputs and edge interrupts.
// Edge/status/irq logic is built only when GPIO_IRQ_EN is defined.
module wb_gpio_bank #(
  parameter int          N_GPIO      = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [N_GPIO-1:0] gpio_i,
  output logic [N_GPIO-1:0] gpio_o,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq_o
);
  localparam logic [31:0] NM = 32'((64'd1 << N_GPIO) - 64'd1);
  logic acc, wr, ack_q, ack_d, unused;
  logic [2:0] off;
  logic [31:0] bm, wd, in_w, rd, out_q, out_d, oe_q, oe_d, dat_q, dat_d;
  logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_q;
  logic [N_GPIO-1:0] in_s;
  assign unused = ^wbs_adr_i[1:0];
  assign acc = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]) & ~ack_q;
  assign wr = acc & wbs_we_i;
  assign off = wbs_adr_i[4:2];
  assign bm = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}} & NM;
  assign wd = wbs_dat_i & bm;
  assign in_s = sync_q[SYNC_STAGES-1];
  assign in_w = 32'(in_s);
  assign gpio_o = out_q[N_GPIO-1:0];
  assign gpio_oe = oe_q[N_GPIO-1:0];
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
`ifdef GPIO_IRQ_EN
  logic [31:0] ren_q, ren_d, fen_q, fen_d, st_q, st_d, ev;
  logic [N_GPIO-1:0] prev_q;
  logic irq_q;
  assign ev = 32'((in_s & ~prev_q & ren_q[N_GPIO-1:0]) | (~in_s & prev_q & fen_q[N_GPIO-1:0]));
  assign irq_o = irq_q;
  always_comb begin
    ren_d = (wr && off == 3'd3) ? (ren_q & ~bm) | wd : ren_q;
    fen_d = (wr && off == 3'd4) ? (fen_q & ~bm) | wd : fen_q;
    // a new edge overrides a simultaneous write-1-to-clear
    st_d = ((wr && off == 3'd5) ? st_q & ~wd : st_q) | ev;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      ren_q  <= '0;
      fen_q  <= '0;
      st_q   <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ren_q  <= ren_d;
      fen_q  <= fen_d;
      st_q   <= st_d;
      prev_q <= in_s;
      irq_q  <= |st_q;
    end
`else
  logic [31:0] ren_q, fen_q, st_q;
  assign ren_q = '0;
  assign fen_q = '0;
  assign st_q = '0;
  assign irq_o = 1'b0;
`endif
  always_comb begin
    out_d = !wr ? out_q :
            off == 3'd0 ? (out_q & ~bm) | wd :
            off == 3'd6 ? out_q | wd :
            off == 3'd7 ? out_q & ~wd : out_q;
    oe_d = (wr && off == 3'd1) ? (oe_q & ~bm) | wd : oe_q;
    rd = off == 3'd0 ? out_q :
         off == 3'd1 ? oe_q :
         off == 3'd2 ? in_w :
         off == 3'd3 ? ren_q :
         off == 3'd4 ? fen_q :
         off == 3'd5 ? st_q : '0;
    ack_d = acc;
    dat_d = (acc & ~wbs_we_i) ? rd : '0;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      out_q  <= '0;
      oe_q   <= '0;
      sync_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
endmodule

// File: doc/wb_gpio_bank.md
WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

Interface
REQ-001 SHALL have parameter N_GPIO, default 32, number of GPIO lines (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-003 SHALL have parameter BASE_ADR, default 32'h3000_0000, register block base address; decode uses wbs_adr_i[31:5] only.
REQ-004 SHALL have wb_clk_i  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write.
REQ-007 SHALL have wbs_sel_i  in  4  byte lanes; wbs_dat_i  in  32  write data; wbs_adr_i  in  32  address.
REQ-008 SHALL have wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-009 SHALL have gpio_i  in  N_GPIO  pad inputs (asynchronous); gpio_o  out  N_GPIO  pad outputs; gpio_oe  out  N_GPIO  output enables, 1 = drive.
REQ-010 SHALL have irq_o  out  1  level interrupt.

Function
REQ-011 Register map (offset): 0x00 OUT rw, 0x04 OE rw, 0x08 IN ro, 0x0C RISE_EN rw, 0x10 FALL_EN rw, 0x14 STATUS rw1c, 0x18 SET wo, 0x1C CLR wo.
REQ-012 Access SHALL be accepted when wbs_cyc_i & wbs_stb_i & address hit & ~wbs_ack_o; wbs_ack_o SHALL pulse exactly one cycle, one cycle after acceptance.
REQ-013 Back-to-back held strobe SHALL produce ack every second cycle; no ack for address miss.
REQ-014 Write effects SHALL apply on the acceptance edge, honouring wbs_sel_i per byte; bits >= N_GPIO ignored.
REQ-015 Reads SHALL return registered data with ack; bits >= N_GPIO read 0; SET, CLR and unmapped offsets read 0.
REQ-016 SET write: OUT |= data; CLR write: OUT &= ~data; SET/CLR affect only selected byte lanes.
REQ-017 gpio_o SHALL equal OUT and gpio_oe SHALL equal OE, both direct register outputs.
REQ-018 gpio_i SHALL pass through SYNC_STAGES flops; IN SHALL show synchronized value; latency pad-to-IN = SYNC_STAGES cycles.
REQ-019 Edge detect SHALL compare synchronized value with its one-cycle-delayed copy; rising edge with RISE_EN bit sets STATUS bit, falling edge with FALL_EN sets STATUS bit.
REQ-020 STATUS write of 1 SHALL clear the bit; an edge event in the same cycle as its W1C SHALL win (bit remains 1).
REQ-021 irq_o SHALL be registered OR of STATUS, asserting one cycle after STATUS sets.
REQ-022 Enabling RISE_EN/FALL_EN SHALL NOT by itself set STATUS for an already-stable level.

Reset
REQ-023 On wb_rst_i high, immediately and asynchronously: OUT, OE, RISE_EN, FALL_EN, STATUS, sync and delay flops = 0; wbs_ack_o = 0; wbs_dat_o = 0; irq_o = 0.
REQ-024 Reset during a pending access SHALL abort it; no ack after reset release for that access.
REQ-025 First edge detection after reset SHALL need SYNC_STAGES+1 cycles; no spurious edges from reset-zero history for inputs held low.

Configuration
REQ-026 Macro GPIO_IRQ_EN: defined -> REQ-019..REQ-022 implemented; undefined -> no edge/status logic, RISE_EN/FALL_EN/STATUS read 0, writes ignored, irq_o tied 0.

Verification
REQ-027 Write OUT=0xA5A5_A5A5 sel=4'b1111, then OE=0xFFFF_0000 -> gpio_o=0xA5A5_A5A5, gpio_oe=0xFFFF_0000, each ack 1 cycle wide, 1 cycle after strobe.
REQ-028 OUT=0x0000_00F0, SET 0x0F sel=4'b0001, CLR 0x30 -> OUT reads 0x0000_00CF; SET with sel=4'b0000 -> no change.
REQ-029 Drive gpio_i[3] 0->1, RISE_EN=0x8 -> IN[3]=1 after 2 cycles, STATUS=0x8, irq_o=1; write STATUS 0x8 -> irq_o=0 next cycle.
REQ-030 Falling edge on gpio_i[0] (FALL_EN=1) timed to coincide with W1C of STATUS bit 0 -> STATUS[0]=1, irq_o stays 1.
REQ-031 N_GPIO=8: write OUT=0xFFFF_FFFF -> read 0x0000_00FF; read offset 0x1C and 0x18 -> 0; address BASE_ADR+0x20 -> no ack.
REQ-032 Assert wb_rst_i mid-access with OUT=0x55 -> gpio_o=0 same cycle asynchronously, no ack; without GPIO_IRQ_EN, edges never raise irq_o.
